regfile_read_arbiter: RTL and testbench

Round-robin arbiter sharing the single 32×32 integer register-file read port among several requesters, e.g. decode rs1, decode rs2 and a debug/trace reader. It drives the register-file read select, captures the selected 32-bit read data into a registered response tagged with the winning requester, and applies write-back bypass and x0-is-zero rules. It sits between the register-file read mux and its consumers.

---
 rtl/regfile_read_arbiter_pkg.sv | 23 ++
 rtl/regfile_read_arbiter_rr_arbiter.sv | 37 +++
 rtl/regfile_read_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_read_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_read_arbiter_pkg.sv
// Shared definitions for the register-file read arbiter: default widths,
// the x0 address, response-register control states and the tag-width rule.
package regfile_read_arbiter_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned AW      = 5;
   localparam int unsigned MIN_REQ = 2;
   localparam int unsigned MAX_REQ = 8;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   // Response register occupancy
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } rsp_state_e;

   // Response tag must be able to name every requester
   function automatic bit idw_fits(input int unsigned num_req, input int unsigned idw);
      return (64'(1) << idw) >= 64'(num_req);
   endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// last_grant+1 (mod NUM_REQ).
//   req          in  NUM_REQ  request vector
//   last_grant   in  GW       index granted most recently
//   grant_c      out NUM_REQ  one-hot winner (zero when no request)
//   grant_idx_c  out GW       binary winner index
//   any_c        out 1        at least one request present
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned GW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GW-1:0]      last_grant,
   output logic [NUM_REQ-1:0] grant_c,
   output logic [GW-1:0]      grant_idx_c,
   output logic               any_c
);
   import regfile_read_arbiter_pkg::*;

   // Priority search rotated to start just past the previous winner
   always_comb begin
      logic [GW-1:0] idx;
      grant_c     = '0;
      grant_idx_c = '0;
      any_c       = 1'b0;
      idx         = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         idx = GW'((32'(last_grant) + off) % NUM_REQ);
         if (!any_c && req[idx]) begin
            any_c        = 1'b1;
            grant_c[idx] = 1'b1;
            grant_idx_c  = idx;
         end
      end
   end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the single register-file read port among NUM_REQ requesters with
// round-robin priority, applies x0/write-back-bypass rules and holds the
// result in a one-entry response register tagged with the winner.
//   clk, rst_n          clock, async active-low reset
//   req_valid/req_addr  per-requester read requests (packed addresses)
//   req_ready           one-hot grant (combinational)
//   rf_sel / rf_data    register-file read select (combinational) and data
//   wr_en/addr/data     same-cycle write-back for bypass
//   rsp_valid/id/data   registered response; rsp_ready accepts it
module regfile_read_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned XLEN    = regfile_read_arbiter_pkg::XLEN,
   parameter int unsigned AW      = regfile_read_arbiter_pkg::AW,
   parameter int unsigned IDW     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [AW-1:0]         rf_sel,
   input  logic [XLEN-1:0]       rf_data,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [XLEN-1:0]       wr_data,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [XLEN-1:0]       rsp_data,
   input  logic                  rsp_ready
);
   import regfile_read_arbiter_pkg::*;

   localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (!idw_fits(NUM_REQ, IDW)) begin : g_bad_idw
      $error("IDW too narrow to tag NUM_REQ requesters");
   end
   if (NUM_REQ < MIN_REQ || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("NUM_REQ out of supported range");
   end

   rsp_state_e           state_q, state_d;
   logic [GW-1:0]        last_grant;
   logic [NUM_REQ-1:0]   arb_grant_c;
   logic [GW-1:0]        arb_idx_c;
   logic                 arb_any_c;
   logic                 can_issue_c;
   logic                 issue_c;
   logic [XLEN-1:0]      rd_val_c;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .GW      (GW)
   ) u_rr_arbiter (
      .req         (req_valid),
      .last_grant  (last_grant),
      .grant_c     (arb_grant_c),
      .grant_idx_c (arb_idx_c),
      .any_c       (arb_any_c)
   );

   assign rsp_valid = (state_q == FULL);

   // Grants are suppressed while reset is asserted so req_ready/rf_sel read zero
   assign can_issue_c = rst_n && (!rsp_valid || rsp_ready);
   assign issue_c     = can_issue_c && arb_any_c;
   assign req_ready   = issue_c ? arb_grant_c : '0;

   // One-hot mux of the winner's address onto the read select
   always_comb begin
      rf_sel = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (req_ready[i]) begin
            rf_sel = rf_sel | req_addr[i*AW +: AW];
         end
      end
   end

   // x0 reads as zero; a same-cycle write-back overrides stale rf_data
   always_comb begin
      rd_val_c = rf_data;
      if (rf_sel == AW'(REG_ZERO)) begin
         rd_val_c = '0;
      end else if (wr_en && (wr_addr == rf_sel)) begin
         rd_val_c = wr_data;
      end
   end

   // Response register occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (issue_c)                state_d = FULL;
         FULL:  if (rsp_ready && !issue_c)  state_d = EMPTY;
         default:                           state_d = EMPTY;
      endcase
   end

   // Payload and priority pointer move only on a grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_id     <= '0;
         rsp_data   <= '0;
         last_grant <= GW'(NUM_REQ - 1);
      end else if (issue_c) begin
         rsp_id     <= IDW'(arb_idx_c);
         rsp_data   <= rd_val_c;
         last_grant <= arb_idx_c;
      end
   end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: a spec-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_read_arbiter;

   localparam int NR = 3;
   localparam int XL = 32;
   localparam int A  = 5;
   localparam int ID = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR*A-1:0] req_addr;
   logic [NR-1:0]   req_ready;
   logic [A-1:0]    rf_sel;
   logic [XL-1:0]   rf_data;
   logic            wr_en;
   logic [A-1:0]    wr_addr;
   logic [XL-1:0]   wr_data;
   logic            rsp_valid;
   logic [ID-1:0]   rsp_id;
   logic [XL-1:0]   rsp_data;
   logic            rsp_ready;

   always #5 clk = ~clk;

   regfile_read_arbiter #(
      .NUM_REQ (NR),
      .XLEN    (XL),
      .AW      (A),
      .IDW     (ID)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .rf_sel    (rf_sel),
      .rf_data   (rf_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready)
   );

   // Register file; x0 deliberately holds garbage so the zero rule is exercised
   logic [XL-1:0] rf [32];
   logic          init_done;

   function automatic logic [31:0] base_val(input int i);
      if (i == 0) return 32'hFFFF_FFFF;
      if (i == 5) return 32'h1234_5678;
      if (i == 7) return 32'hAAAA_AAAA;
      return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
   endfunction

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 32; i++) rf[i] <= base_val(i);
      end else if (wr_en && wr_addr != 0) begin
         rf[wr_addr] <= wr_data;
      end
   end

   assign rf_data = rf[rf_sel];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int winner(input logic [NR-1:0] v, input int last);
      for (int off = 1; off <= NR; off++) begin
         int i;
         i = (last + off) % NR;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [A-1:0] addr_of(input int i);
      return req_addr[i*A +: A];
   endfunction

   function automatic logic [31:0] read_val(input logic [A-1:0] a);
      if (a == 0) return 32'h0;
      if (wr_en && wr_addr == a) return wr_data;
      return rf[a];
   endfunction

   logic          m_valid;
   int            m_id;
   logic [31:0]   m_data;
   int            m_last;

   always @(posedge clk or negedge rst_n) begin
      int w;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_id    = 0;
         m_data  = '0;
         m_last  = NR - 1;
      end else begin
         w = (!m_valid || rsp_ready) ? winner(req_valid, m_last) : -1;
         if (w >= 0) begin
            m_valid = 1'b1;
            m_id    = w;
            m_data  = read_val(addr_of(w));
            m_last  = w;
         end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Per-cycle comparison on the falling edge
   always @(negedge clk) begin
      int w;
      logic [NR-1:0] exp_rdy;
      logic [A-1:0]  exp_sel;
      if (!rst_n) begin
         chk("rst_req_ready", 32'(req_ready), 32'h0);
         chk("rst_rf_sel", 32'(rf_sel), 32'h0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      end else begin
         w = (!m_valid || rsp_ready) ? winner(req_valid, m_last) : -1;
         exp_rdy = '0;
         exp_sel = '0;
         if (w >= 0) begin
            exp_rdy[w] = 1'b1;
            exp_sel    = addr_of(w);
         end
         chk("mdl_req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("mdl_rf_sel", 32'(rf_sel), 32'(exp_sel));
         chk("mdl_rsp_valid", 32'(rsp_valid), 32'(m_valid));
         if (m_valid) begin
            chk("mdl_rsp_id", 32'(rsp_id), 32'(m_id));
            chk("mdl_rsp_data", rsp_data, m_data);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [A-1:0] a);
      req_addr[i*A +: A] = a;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      rsp_ready = 1'b0;
      init_done = 1'b0;

      // Reset: grants gated even with requests present
      @(posedge clk);
      #1;
      init_done = 1'b1;
      req_valid = 3'b111;
      #1;
      chk("reset_req_ready", 32'(req_ready), 32'h0);
      chk("reset_rf_sel", 32'(rf_sel), 32'h0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_rsp_id", 32'(rsp_id), 32'h0);
      chk("reset_rsp_data", rsp_data, 32'h0);
      tick();

      // Single requester after reset
      req_valid = 3'b001;
      set_addr(0, 5'd5);
      rsp_ready = 1'b1;
      rst_n     = 1'b1;
      #1;
      chk("single_ready", 32'(req_ready), 32'h1);
      chk("single_rf_sel", 32'(rf_sel), 32'd5);
      tick();
      chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("single_rsp_id", 32'(rsp_id), 32'h0);
      chk("single_rsp_data", rsp_data, 32'h1234_5678);

      // All requesting, no backpressure: rotation continues from last winner 0
      req_valid = 3'b111;
      set_addr(0, 5'd1);
      set_addr(1, 5'd2);
      set_addr(2, 5'd3);
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rot_grant", 32'(req_ready), 32'(1 << ((k + 1) % 3)));
         tick();
         chk("rot_rsp_id", 32'(rsp_id), 32'((k + 1) % 3));
      end

      // Backpressure: response from requester 0 (addr 1) held
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready", 32'(req_ready), 32'h0);
         tick();
         chk("bp_rsp_id", 32'(rsp_id), 32'h0);
         chk("bp_rsp_data", rsp_data, 32'h1000_0101);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_regrant", 32'(req_ready), 32'b010);
      tick();
      chk("bp_new_id", 32'(rsp_id), 32'h1);
      chk("bp_new_data", rsp_data, 32'h1000_0202);

      // Bypass: write to a different address does not forward
      req_valid = 3'b001;
      set_addr(0, 5'd7);
      wr_en   = 1'b1;
      wr_addr = 5'd8;
      wr_data = 32'h5555_5555;
      #1;
      chk("byp_rf_sel", 32'(rf_sel), 32'd7);
      tick();
      chk("byp_miss_data", rsp_data, 32'hAAAA_AAAA);
      wr_addr = 5'd7;
      tick();
      chk("byp_hit_data", rsp_data, 32'h5555_5555);

      // x0 stays zero despite garbage rf_data and an in-flight write
      set_addr(0, 5'd0);
      wr_addr = 5'd0;
      wr_data = 32'h0000_0001;
      tick();
      chk("x0_rsp_data", rsp_data, 32'h0);
      chk("x0_rsp_valid", 32'(rsp_valid), 32'h1);

      // Reset mid-operation with requester 2 last granted
      wr_en     = 1'b0;
      req_valid = 3'b100;
      set_addr(2, 5'd3);
      tick();
      chk("mid_pre_id", 32'(rsp_id), 32'h2);
      chk("mid_pre_valid", 32'(rsp_valid), 32'h1);
      rsp_ready = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
      chk("mid_rst_id", 32'(rsp_id), 32'h0);
      req_valid = 3'b111;
      set_addr(0, 5'd4);
      set_addr(1, 5'd5);
      set_addr(2, 5'd6);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(req_ready), 32'b001);
      tick();
      chk("post_rst_id0", 32'(rsp_id), 32'h0);
      chk("post_rst_data0", rsp_data, 32'h1000_0404);
      rsp_ready = 1'b1;
      #1;
      chk("post_rst_ready1", 32'(req_ready), 32'b010);
      tick();
      chk("post_rst_data1", rsp_data, 32'h1234_5678);
      tick();
      chk("post_rst_id2", 32'(rsp_id), 32'h2);

      // Drain: response accepted with no new grant empties the register
      req_valid = '0;
      tick();
      chk("drain_valid", 32'(rsp_valid), 32'h0);
      chk("drain_id_hold", 32'(rsp_id), 32'h2);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
